// File: rtl/comparador_serial_ctrl_d_i.sv
// -----------------------------------------------------------------------------
// comparador_serial_ctrl_d_i
//
// Sequencer for a right-to-left iterative magnitude comparator. One comparator
// cell is reused over N clock cycles. Its borrow state (y) is held in a flop
// between cycles. Operand bit pairs are fed LSB-first:
//   - bit 0 is the initial cell,
//   - bits 1..N-2 are the typical cells,
//   - bit N-1 is the final cell, which produces z = (A >= B).
//
// Optional feature (compile-time macro COMPARADOR_EQ_EN):
//   When the macro is defined, an equality flag is tracked alongside the borrow
//   and presented on eq_o. When it is undefined, the eq_o port and its logic
//   do not exist.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start_i  in   1  request; only looked at while idle
//   a_i      in   N  operand A, captured on the accepting edge
//   b_i      in   N  operand B, captured on the accepting edge
//   busy_o   out  1  high while bits are being processed
//   done_o   out  1  one-cycle pulse when the result is valid
//   z_o      out  1  1 = A >= B (unsigned); held until the next done_o
//   eq_o     out  1  (COMPARADOR_EQ_EN only) 1 = A == B; same timing as z_o
//
// Timing
//   Start accepted at edge E0. done_o is high in the cycle after edge E0+N.
//   The next start is sampled at edge E0+N+2.
// -----------------------------------------------------------------------------
module comparador_serial_ctrl_d_i #(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
`ifdef COMPARADOR_EQ_EN
  output logic         eq_o,
`endif
  output logic         z_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               y_q,     y_d;
  logic [N-1:0]       a_q,     a_d;
  logic [N-1:0]       b_q,     b_d;
  logic               z_q,     z_d;
`ifdef COMPARADOR_EQ_EN
  logic               eq_q,    eq_d;
  logic               eq_out_q, eq_out_d;
`endif

  // Bit pair currently presented to the cell.
  logic bit_a;
  logic bit_b;
  assign bit_a = a_q[cnt_q];
  assign bit_b = b_q[cnt_q];

  // Borrow out of the current cell (borrow chain of A - B).
  logic y_cell;
  assign y_cell = (y_q & ~bit_a) | (y_q & bit_b) | (~bit_a & bit_b);

  // Final-cell result. This is equivalent to ~y_cell, i.e. there is no borrow
  // out of the MSB, which means A >= B.
  logic z_cell;
  assign z_cell = (bit_a & ~bit_b) | (~y_q & ~bit_b) | (~y_q & bit_a);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
`ifdef COMPARADOR_EQ_EN
    eq_d     = eq_q;
    eq_out_d = eq_out_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = '0;
          y_d     = 1'b0;
`ifdef COMPARADOR_EQ_EN
          eq_d    = 1'b1;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        y_d = y_cell;
`ifdef COMPARADOR_EQ_EN
        eq_d = eq_q & ~(bit_a ^ bit_b);
`endif
        if (cnt_q == CNT_LAST) begin
          // The counter is held at N-1 here rather than incremented, so it
          // never wraps.
          z_d      = z_cell;
`ifdef COMPARADOR_EQ_EN
          eq_out_d = eq_q & ~(bit_a ^ bit_b);
`endif
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
`ifdef COMPARADOR_EQ_EN
      eq_q     <= 1'b0;
      eq_out_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
`ifdef COMPARADOR_EQ_EN
      eq_q     <= eq_d;
      eq_out_q <= eq_out_d;
`endif
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign z_o    = z_q;
`ifdef COMPARADOR_EQ_EN
  assign eq_o   = eq_out_q;
`endif

endmodule

// File: tb/tb_comparador_serial_ctrl_d_i.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial_ctrl_d_i
//
// Self-checking bench for comparador_serial_ctrl_d_i with N = 8.
//
// The reference model is plain arithmetic:
//   z  = (A >= B)
//   eq = (A == B)
//
// Operation timing is checked cycle by cycle: busy_o must be high for N cycles
// after the accept edge, then done_o must pulse for one cycle.
// -----------------------------------------------------------------------------
module tb_comparador_serial_ctrl_d_i;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic         z_o;
`ifdef COMPARADOR_EQ_EN
  logic         eq_o;
`endif

  comparador_serial_ctrl_d_i #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
`ifdef COMPARADOR_EQ_EN
    .eq_o    (eq_o),
`endif
    .z_o     (z_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_err;
  logic exp_z_prev;
  logic exp_eq_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Runs one comparison and checks it. The caller must leave the DUT in IDLE.
  // When scramble is set, the operand inputs are changed after acceptance; the
  // result must be unaffected.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble);
    logic exp_z;
    logic exp_eq;
    exp_z  = (a >= b);
    exp_eq = (a == b);
    @(negedge clk);
    check_val("idle_busy", busy_o, 0);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(posedge clk);  // accept edge E0
    #1;
    start_i = 1'b0;
    if (scramble) begin
      a_i = N'($urandom);
      b_i = N'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check_val("run_busy", busy_o, 1);
      check_val("run_done", done_o, 0);
      check_val("run_zhold", z_o, exp_z_prev);
`ifdef COMPARADOR_EQ_EN
      check_val("run_eqhold", eq_o, exp_eq_prev);
`endif
      if (scramble) begin
        a_i = N'($urandom);
        b_i = N'($urandom);
      end
    end
    @(negedge clk);  // cycle after edge E0+N
    check_val("done_pulse", done_o, 1);
    check_val("done_busy", busy_o, 0);
    check_val("z", z_o, exp_z);
`ifdef COMPARADOR_EQ_EN
    check_val("eq", eq_o, exp_eq);
`endif
    @(negedge clk);
    check_val("done_clear", done_o, 0);
    check_val("z_stable", z_o, exp_z);
    $display("op A=%02h B=%02h z=%0b exp_z=%0b", a, b, z_o, exp_z);
    exp_z_prev  = exp_z;
    exp_eq_prev = exp_eq;
  endtask

  initial begin
    int   last_done;
    int   done_cnt;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    n_vec       = 0;
    n_err       = 0;
    exp_z_prev  = 1'b0;
    exp_eq_prev = 1'b0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    a_i         = '0;
    b_i         = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_z", z_o, 0);
`ifdef COMPARADOR_EQ_EN
    check_val("rst_eq", eq_o, 0);
`endif
    rst_n = 1'b1;

    // Directed cases, including MSB-decides
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'hA5, 8'hA5, 1'b0);
    do_op(8'hFF, 8'h00, 1'b0);
    do_op(8'h00, 8'hFF, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1);

    // start_i held high: exactly one accept per N+2 cycles. Operand changes
    // while busy are ignored.
    @(negedge clk);
    start_i   = 1'b1;
    a_i       = 8'h80;
    b_i       = 8'h7F;
    last_done = -1;
    done_cnt  = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_o) begin
        check_val("t4_z", z_o, 1);
        if (last_done >= 0) check_val("t4_spacing", c - last_done, N + 2);
        last_done = c;
        done_cnt++;
        $display("t4 done at cycle %0d z=%0b", c, z_o);
      end
      if (busy_o) begin
        a_i = N'($urandom_range(0, 8'h7F));
        b_i = 8'hFF;
      end else begin
        a_i = 8'h80;
        b_i = 8'h7F;
      end
    end
    check_val("t4_count", (done_cnt >= 5) ? 32'd1 : 32'd0, 1);
    start_i = 1'b0;
    // Let any in-flight operation drain back to IDLE.
    repeat (N + 3) @(negedge clk);
    check_val("t4_idle", busy_o, 0);
    exp_z_prev  = 1'b1;
    exp_eq_prev = 1'b0;

    // Asynchronous reset during RUN aborts without producing done_o
    @(negedge clk);
    start_i = 1'b1;
    a_i     = 8'h12;
    b_i     = 8'h34;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t5_busy_pre", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_busy_async", busy_o, 0);
    check_val("t5_z_async", z_o, 0);
    check_val("t5_done_async", done_o, 0);
    repeat (3) begin
      @(negedge clk);
      check_val("t5_no_done", done_o, 0);
    end
    rst_n       = 1'b1;
    exp_z_prev  = 1'b0;
    exp_eq_prev = 1'b0;
    do_op(8'h34, 8'h12, 1'b0);

    // Random operand pairs; every fourth one also has equal operands
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = ((i % 4) == 3) ? ra : N'($urandom);
      do_op(ra, rb, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
